sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the instruction-fetch (i_*) and data (d_*) requesters.
//  Sits between the IF/MEM stages and the external memory bridge.
//  Requests are split into an address phase (req/addr_ok) and a data phase (data_ok), with responses returned in order.
//  Tracks the owner of every outstanding transaction and steers data_ok to the requester that issued it.
// PARAMETERS
//  OUTSTANDING   2  max accepted-but-unanswered transactions (owner FIFO depth, >=1)
//  STARVE_LIMIT  4  consecutive data grants allowed while i_req pending before inst is forced (>=1)
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset        in   1   asynchronous, active-high
//  i_req        in   1   inst request; held with fields stable until i_addr_ok
//  i_wr         in   1   write (0 for fetch)
//  i_size       in   2   0=byte 1=half 2=word
//  i_wstrb      in   4   byte write enables
//  i_addr       in   32  byte address
//  i_wdata      in   32  write data
//  i_addr_ok    out  1   inst address phase accepted
//  i_data_ok    out  1   inst data phase complete
//  i_rdata      out  32  read data (= m_rdata)
//  d_req,d_wr,d_size,d_wstrb,d_addr,d_wdata  in  1/1/2/4/32/32  data requester, same rules as i_*
//  d_addr_ok    out  1   data address phase accepted
//  d_data_ok    out  1   data data phase complete
//  d_rdata      out  32  read data (= m_rdata)
//  m_req        out  1   request to memory port
//  m_wr,m_size,m_wstrb,m_addr,m_wdata  out  1/2/4/32/32  fields of granted requester
//  m_addr_ok    in   1   memory accepted address phase
//  m_data_ok    in   1   memory returns one response, in order
//  m_rdata      in   32  memory read data
//  err          out  1   sticky: m_data_ok seen with no outstanding transaction
// BEHAVIOUR
//  FSM states: IDLE, GNT_D, GNT_I (registered).
//  m_req = (state != IDLE). m_* fields are muxed from the owner of the current state. Fields are zero in IDLE.
//  IDLE: no grant if cnt == OUTSTANDING.
//   - Else if d_req and !(i_req && starve == STARVE_LIMIT): go to GNT_D.
//   - Else if i_req: go to GNT_I.
//   - Else stay in IDLE.
//  GNT_x:
//   - x_addr_ok = m_addr_ok. On m_addr_ok, push owner x into the FIFO and go to IDLE.
//   - If x_req drops before m_addr_ok, go to IDLE with no push (cancel).
//  Throughput: at most one address phase every 2 cycles, because IDLE is a one-cycle arbitration bubble.
//  starve counter:
//   - Increments, saturating at STARVE_LIMIT, on each entry to GNT_D while i_req = 1.
//   - Clears on entry to GNT_I.
//   - Holds otherwise.
//  Owner FIFO (depth OUTSTANDING, 1 bit per entry, 0=inst 1=data):
//   - Push on m_req & m_addr_ok. Pop on m_data_ok & cnt != 0.
//   - A simultaneous push and pop leaves cnt unchanged.
//   - Pointers wrap modulo OUTSTANDING.
//  i_data_ok = m_data_ok & cnt != 0 & head == 0.
//  d_data_ok = m_data_ok & cnt != 0 & head == 1.
//  Latency: data_ok is combinational from m_data_ok, same cycle. addr_ok is combinational from m_addr_ok.
//  m_data_ok while cnt == 0: ignored (no data_ok, no pop) and err set. Only reset clears err.
//  Reset values: state = IDLE, cnt = 0, pointers = 0, starve = 0, err = 0.
//   - Hence m_req = 0, all addr_ok/data_ok = 0, m_* fields = 0.
//  Reset mid-transaction: outstanding transactions are dropped. Late m_data_ok after reset only sets err.
// TESTING
//  1. reset; i_req=1 fetch addr 0xBFC00000; m_addr_ok=1 on 2nd cycle -> m_req=1 from cycle 2, i_addr_ok pulse, cnt=1; m_data_ok with rdata 0x3C1D0000 -> i_data_ok=1, i_rdata=0x3C1D0000.
//  2. i_req and d_req raised the same cycle, starve=0 -> GNT_D first, then GNT_I; responses returned in push order (d then i).
//  3. d_req held continuously with i_req=1, STARVE_LIMIT=4 -> four data grants, 5th grant goes to inst, starve=0 afterwards.
//  4. OUTSTANDING=2, two grants accepted with no m_data_ok -> m_req stays 0 in IDLE; one m_data_ok -> next grant proceeds.
//  5. m_data_ok pulsed with cnt=0 -> no data_ok, err=1 sticky until reset.
//  6. reset asserted while in GNT_D with cnt=1 -> m_req=0 immediately, cnt=0; d_req withdrawn in GNT_D -> IDLE, cnt unchanged.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like memory port between the instruction-fetch
// (i_*) and data (d_*) requesters. Address phases are arbitrated one at a time, with
// a one-cycle IDLE bubble between grants. Responses come back in order, and each one
// is steered to the requester that issued it by an owner FIFO.
//
// Ports
//   clk, reset                                  clock; asynchronous active-high reset
//   i_req/i_wr/i_size/i_wstrb/i_addr/i_wdata    instruction requester, fields held until i_addr_ok
//   i_addr_ok, i_data_ok, i_rdata               instruction handshakes / read data
//   d_req/d_wr/d_size/d_wstrb/d_addr/d_wdata    data requester, same rules
//   d_addr_ok, d_data_ok, d_rdata               data handshakes / read data
//   m_req/m_wr/m_size/m_wstrb/m_addr/m_wdata    request to the memory bridge
//   m_addr_ok, m_data_ok, m_rdata               memory handshakes / read data
//   err                                         sticky: response seen with nothing outstanding
module sram_port_arbiter #(
    parameter int unsigned OUTSTANDING  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        err
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } state_t;

    state_t           state;
    logic [STV_W-1:0] starve;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OUTSTANDING-1:0] owner_q;   // 0 = inst, 1 = data

    logic push;
    logic pop;
    logic head;
    logic full;
    logic starved;
    req_t sel;

    assign full    = (cnt == CNT_W'(OUTSTANDING));
    assign starved = i_req && (starve == STV_W'(STARVE_LIMIT));
    assign push    = m_req && m_addr_ok;
    assign pop     = m_data_ok && (cnt != '0);
    assign head    = owner_q[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Arbitration FSM and anti-starvation counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!full) begin
                        if (d_req && !starved) begin
                            state <= GNT_D;
                            if (i_req && (starve != STV_W'(STARVE_LIMIT)))
                                starve <= starve + STV_W'(1);
                        end else if (i_req) begin
                            state  <= GNT_I;
                            starve <= '0;
                        end
                    end
                end
                // An accept takes priority over a same-cycle withdrawal.
                GNT_D:   if (m_addr_ok || !d_req) state <= IDLE;
                GNT_I:   if (m_addr_ok || !i_req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Owner FIFO: records who issued each accepted address phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            owner_q <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr] <= (state == GNT_D);
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error for a response that has no matching transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (m_data_ok && (cnt == '0))
            err <= 1'b1;
    end

    // Request fields come from the current owner; zero while idle.
    always_comb begin
        sel = '0;
        case (state)
            GNT_D:   sel = '{wr: d_wr, size: d_size, wstrb: d_wstrb, addr: d_addr, wdata: d_wdata};
            GNT_I:   sel = '{wr: i_wr, size: i_size, wstrb: i_wstrb, addr: i_addr, wdata: i_wdata};
            default: sel = '0;
        endcase
    end

    assign m_req   = (state != IDLE);
    assign m_wr    = sel.wr;
    assign m_size  = sel.size;
    assign m_wstrb = sel.wstrb;
    assign m_addr  = sel.addr;
    assign m_wdata = sel.wdata;

    assign i_addr_ok = (state == GNT_I) && m_addr_ok;
    assign d_addr_ok = (state == GNT_D) && m_addr_ok;
    assign i_data_ok = pop && !head;
    assign d_data_ok = pop && head;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (OUTSTANDING=2, STARVE_LIMIT=4).
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [3:0]  i_wstrb, d_wstrb;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        err;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h8000_1002;

    sram_port_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        i_req = 0; i_wr = 0; i_size = 2'd2; i_wstrb = 4'h0; i_addr = IA; i_wdata = '0;
        d_req = 0; d_wr = 1; d_size = 2'd1; d_wstrb = 4'hC; d_addr = DA; d_wdata = 32'hCAFE_F00D;
        m_addr_ok = 1'b1; m_data_ok = 1'b0; m_rdata = '0;

        // reset state
        repeat (2) tick();
        #1;
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_i_addr_ok", 32'(i_addr_ok), 32'd0);
        chk("rst_d_addr_ok", 32'(d_addr_ok), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);

        // 1: single fetch
        tick(); reset = 0; m_addr_ok = 0; i_req = 1;
        #1 chk("t1_idle_m_req", 32'(m_req), 32'd0);
        tick();
        #1 chk("t1_gnt_m_req", 32'(m_req), 32'd1);
        chk("t1_m_addr", m_addr, IA);
        chk("t1_m_size", 32'(m_size), 32'd2);
        chk("t1_m_wr", 32'(m_wr), 32'd0);
        chk("t1_wait_i_addr_ok", 32'(i_addr_ok), 32'd0);
        m_addr_ok = 1;
        #1 chk("t1_i_addr_ok", 32'(i_addr_ok), 32'd1);
        chk("t1_d_addr_ok", 32'(d_addr_ok), 32'd0);
        tick(); i_req = 0; m_addr_ok = 0;
        #1 chk("t1_back_idle", 32'(m_req), 32'd0);
        chk("t1_idle_addr_zero", m_addr, 32'd0);
        m_data_ok = 1; m_rdata = 32'h3C1D_0000;
        #1 chk("t1_i_data_ok", 32'(i_data_ok), 32'd1);
        chk("t1_d_data_ok", 32'(d_data_ok), 32'd0);
        chk("t1_i_rdata", i_rdata, 32'h3C1D_0000);
        tick(); m_data_ok = 0;

        // 2: simultaneous requests, data first, in-order responses
        i_req = 1; d_req = 1;
        tick();
        #1 chk("t2_gnt_d_m_req", 32'(m_req), 32'd1);
        chk("t2_gnt_d_addr", m_addr, DA);
        chk("t2_gnt_d_wr", 32'(m_wr), 32'd1);
        chk("t2_gnt_d_wstrb", 32'(m_wstrb), 32'hC);
        chk("t2_gnt_d_wdata", m_wdata, 32'hCAFE_F00D);
        m_addr_ok = 1;
        #1 chk("t2_d_addr_ok", 32'(d_addr_ok), 32'd1);
        chk("t2_i_addr_ok_low", 32'(i_addr_ok), 32'd0);
        tick(); d_req = 0; m_addr_ok = 0;
        #1 chk("t2_bubble", 32'(m_req), 32'd0);
        tick();
        #1 chk("t2_gnt_i_addr", m_addr, IA);
        m_addr_ok = 1;
        #1 chk("t2_i_addr_ok", 32'(i_addr_ok), 32'd1);
        tick(); i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1111_2222;
        #1 chk("t2_first_resp_d", 32'(d_data_ok), 32'd1);
        chk("t2_first_resp_not_i", 32'(i_data_ok), 32'd0);
        chk("t2_d_rdata", d_rdata, 32'h1111_2222);
        tick();
        #1 chk("t2_second_resp_i", 32'(i_data_ok), 32'd1);
        chk("t2_second_resp_not_d", 32'(d_data_ok), 32'd0);
        tick(); m_data_ok = 0;

        // 3: starvation limit, four data grants then inst
        i_req = 1; d_req = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1 chk($sformatf("t3_grant%0d_addr", k), m_addr, (k < 4) ? DA : IA);
            m_addr_ok = 1; m_data_ok = (k > 0);
            #1;
            if (k > 0) chk($sformatf("t3_grant%0d_pop_d", k), 32'(d_data_ok), 32'd1);
            tick(); m_addr_ok = 0; m_data_ok = 0;
            if (k == 4) begin i_req = 0; d_req = 0; end
            #1 chk($sformatf("t3_bubble%0d", k), 32'(m_req), 32'd0);
        end
        m_data_ok = 1;
        #1 chk("t3_inst_resp", 32'(i_data_ok), 32'd1);
        tick(); m_data_ok = 0; i_req = 1; d_req = 1;
        tick();
        #1 chk("t3_starve_cleared", m_addr, DA);
        m_addr_ok = 1;
        tick(); m_addr_ok = 0; i_req = 0; d_req = 0; m_data_ok = 1;
        #1 chk("t3_drain_d", 32'(d_data_ok), 32'd1);
        tick(); m_data_ok = 0;

        // 4: outstanding limit blocks grants until a response
        d_req = 1;
        tick();
        #1 chk("t4_gnt1", 32'(m_req), 32'd1);
        m_addr_ok = 1;
        tick(); m_addr_ok = 0;
        tick();
        #1 chk("t4_gnt2", 32'(m_req), 32'd1);
        m_addr_ok = 1;
        tick(); m_addr_ok = 0;
        #1 chk("t4_full_idle_a", 32'(m_req), 32'd0);
        tick();
        #1 chk("t4_full_idle_b", 32'(m_req), 32'd0);
        m_data_ok = 1;
        #1 chk("t4_pop", 32'(d_data_ok), 32'd1);
        tick(); m_data_ok = 0;
        #1 chk("t4_still_idle", 32'(m_req), 32'd0);
        tick();
        #1 chk("t4_resume", 32'(m_req), 32'd1);
        m_addr_ok = 1;
        tick(); m_addr_ok = 0; d_req = 0; m_data_ok = 1;
        #1 chk("t4_drain1", 32'(d_data_ok), 32'd1);
        tick();
        #1 chk("t4_drain2", 32'(d_data_ok), 32'd1);
        tick(); m_data_ok = 0;

        // 5: stray response sets sticky err
        #1 chk("t5_err_before", 32'(err), 32'd0);
        m_data_ok = 1;
        #1 chk("t5_no_d_data_ok", 32'(d_data_ok), 32'd0);
        chk("t5_no_i_data_ok", 32'(i_data_ok), 32'd0);
        tick(); m_data_ok = 0;
        #1 chk("t5_err_set", 32'(err), 32'd1);
        repeat (3) tick();
        #1 chk("t5_err_sticky", 32'(err), 32'd1);

        // 6a: withdrawal in GNT_D cancels without a push
        d_req = 1;
        tick(); m_addr_ok = 1;
        tick(); m_addr_ok = 0;
        tick();
        #1 chk("t6_gnt_d", 32'(m_req), 32'd1);
        d_req = 0;
        tick();
        #1 chk("t6_cancel_idle", 32'(m_req), 32'd0);
        tick();
        #1 chk("t6_cancel_stays", 32'(m_req), 32'd0);
        m_data_ok = 1;
        #1 chk("t6_kept_entry", 32'(d_data_ok), 32'd1);
        tick();
        #1 chk("t6_no_extra_entry", 32'(d_data_ok), 32'd0);
        tick(); m_data_ok = 0;

        // 6b: reset in GNT_D with one outstanding drops everything
        reset = 1;
        #1 chk("t6_err_cleared", 32'(err), 32'd0);
        tick(); reset = 0; d_req = 1;
        tick(); m_addr_ok = 1;
        tick(); m_addr_ok = 0;
        tick();
        #1 chk("t6_gnt_d_again", 32'(m_req), 32'd1);
        reset = 1; m_addr_ok = 1;
        #1 chk("t6_rst_m_req", 32'(m_req), 32'd0);
        chk("t6_rst_d_addr_ok", 32'(d_addr_ok), 32'd0);
        chk("t6_rst_m_addr", m_addr, 32'd0);
        tick(); reset = 0; d_req = 0; m_addr_ok = 0; m_data_ok = 1;
        #1 chk("t6_late_resp_dropped", 32'(d_data_ok), 32'd0);
        tick(); m_data_ok = 0;
        #1 chk("t6_late_resp_err", 32'(err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
